// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmemState_t;

    localparam int unsigned WAIT_CNT_W      = 4;
    localparam int unsigned DMEM_DATA_WIDTH = 16;
    localparam int unsigned DMEM_ADDR_WIDTH = 8;

endpackage

// File: rtl/dmem_array.sv
// Single-port RAM, synchronous write and synchronous read. Only the read register is reset;
// the storage array keeps its contents across reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its value between loads so the load result stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts MEM-stage loads/stores, stalls the pipeline for the access,
// then pulses rvalid_o. Define DMEM_POSTED_WR_EN to commit stores on the accept edge without stall.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DMEM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DMEM_ADDR_WIDTH,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_rd_i,
    input  logic                  req_wr_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  stall_o,
    output logic                  rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    // BUSY lasts WAIT_CYCLES cycles, so the counter loads one less than the wait count and the
    // access executes on the edge that ends the last wait state.
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);
    localparam logic NO_WAIT = (WAIT_CYCLES == 0);

    dmemState_t            state, stateNext;
    logic [WAIT_CNT_W-1:0] cnt, cntNext;
    logic [ADDR_WIDTH-1:0] addrQ, addrD;
    logic [DATA_WIDTH-1:0] wdataQ, wdataD;
    logic                  opWrQ, opWrD;

    logic                  postedWr;
    logic                  fsmReq;
    logic                  acceptNow;
    logic                  execNow;
    logic                  execWr;
    logic                  arrWe;
    logic                  arrRe;
    logic [ADDR_WIDTH-1:0] arrAddr;
    logic [DATA_WIDTH-1:0] arrWdata;

`ifdef DMEM_POSTED_WR_EN
    assign postedWr = (state == IDLE) & req_wr_i;
    assign fsmReq   = req_rd_i & ~req_wr_i;
`else
    assign postedWr = 1'b0;
    assign fsmReq   = req_rd_i | req_wr_i;
`endif

    assign acceptNow = (state == IDLE) & fsmReq;
    assign execNow   = (acceptNow & NO_WAIT) | ((state == BUSY) & (cnt == '0));

    // In IDLE the array sees the live request; otherwise the latched one.
    assign execWr   = (state == IDLE) ? req_wr_i : opWrQ;
    assign arrAddr  = (state == IDLE) ? addr_i : addrQ;
    assign arrWdata = (state == IDLE) ? wdata_i : wdataQ;

    // Reset on the commit edge drops the access.
    assign arrWe = ~rst & (postedWr | (execNow & execWr));
    assign arrRe = ~rst & execNow & ~execWr;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arrWe),
        .re    (arrRe),
        .addr  (arrAddr),
        .wdata (arrWdata),
        .rdata (rdata_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addrQ  <= '0;
            wdataQ <= '0;
            opWrQ  <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            addrQ  <= addrD;
            wdataQ <= wdataD;
            opWrQ  <= opWrD;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        addrD     = addrQ;
        wdataD    = wdataQ;
        opWrD     = opWrQ;
        unique case (state)
            IDLE: begin
                if (acceptNow) begin
                    addrD     = addr_i;
                    wdataD    = wdata_i;
                    opWrD     = req_wr_i;
                    cntNext   = CNT_LOAD;
                    stateNext = NO_WAIT ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    stateNext = RESP;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            RESP: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        stall_o  = ((state == IDLE) & fsmReq) | (state == BUSY);
        rvalid_o = (state == RESP);
    end

endmodule
